deserializer_lanes: RTL and testbench
=====================================

Name: deserializer_lanes

Overview:
- Parametrised successor to the single-bit deserializer: collects LANE_W-bit beats into DATA_W-bit words.
- Bit order is selectable. A last flag flushes partial words.
- The output holds each word under a valid/ready handshake that back-pressures the serial source.
- Sits between a serial/narrow link front-end and word-wide processing logic.

Parameters:
- DATA_W, 16, output word width; must be a multiple of LANE_W.
- LANE_W, 1, bits per input beat; 1 <= LANE_W <= DATA_W.
- MSB_FIRST, 1, 1: first beat lands in the most significant lane; 0: first beat lands in the least significant lane.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_n_i  in  1  synchronous reset, active-low.
- data_i  in  LANE_W  input beat.
- data_val_i  in  1  beat valid.
- data_last_i  in  1  qualified by data_val_i; the beat is the final one of the word (may be partial).
- data_ready_o  out  1  beat accepted when data_val_i && data_ready_o.
- deser_data_o  out  DATA_W  assembled word.
- deser_len_o  out  $clog2(DATA_W+1)  number of valid bits in deser_data_o.
- deser_data_val_o  out  1  word valid.
- deser_data_ready_i  in  1  downstream accepts word when deser_data_val_o && deser_data_ready_i.

Behaviour:
- BEATS = DATA_W/LANE_W. Internal beat counter cnt in 0..BEATS-1 and a shift/assembly register.
- Reset (srst_n_i low at an edge): deser_data_o=0, deser_len_o=0, deser_data_val_o=0, cnt=0, assembly register=0. Any partial word is discarded. Reset overrides all other events in the same cycle.
- data_ready_o = !deser_data_val_o || deser_data_ready_i. This path is combinational. The input stalls only while a completed word is held and not being taken.
- Beat acceptance, MSB_FIRST=1: assembly shifts left by LANE_W and takes data_i in the LSBs.
- Beat acceptance, MSB_FIRST=0: assembly shifts right by LANE_W and takes data_i in the MSBs.
- Gaps (data_val_i low) hold cnt and assembly unchanged.
- Word completes on an accepted beat with cnt==BEATS-1 or with data_last_i=1.
- On the next edge after completion:
  - deser_data_val_o=1.
  - deser_len_o=(cnt+1)*LANE_W.
  - cnt returns to 0 and the assembly register clears.
- Latency: word valid exactly 1 cycle after its final beat is accepted.
- Partial word, MSB_FIRST=1: bits left-justified; received beat k occupies lane BEATS-1-k; unused LSBs are 0.
- Partial word, MSB_FIRST=0: bits right-justified; beat k occupies lane k; unused MSBs are 0.
- Full-word data matches the original: MSB-first serial of value V yields V.
- Output register holds data/len/val stable while deser_data_val_o && !deser_data_ready_i.
- If no new word completes in the same cycle, val clears on handshake.
- Simultaneous handshake and completion: the new word loads and val stays 1, giving back-to-back words with no bubble.
- data_last_i when data_val_i=0 is ignored. data_last_i on the BEATS-th beat is a normal full word (len=DATA_W).
- Beats presented while data_ready_o=0 are not consumed; the source must hold them.

Optional Feature:
- Macro: DESERIALIZER_LANES_OVF_CNT_EN.
- Defined: adds output ovf_cnt_o [15:0], reset to 0. It increments (saturating at 16'hFFFF) on every cycle with data_val_i=1 && data_ready_o=0, i.e. a stalled beat, for link-stall profiling.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- DATA_W=16, LANE_W=1, MSB_FIRST=1, ready_i=1: 16 consecutive bits of 16'hA5C3 -> val=0 during the 16 beats; next cycle val=1, data=16'hA5C3, len=16. Repeat 100 random words.
- LANE_W=4, MSB_FIRST=0, beats 4'h1,4'h2,4'h3,4'h4 -> data=16'h4321, len=16, 1 cycle after the 4th beat.
- LANE_W=4, MSB_FIRST=1: beats 4'hA, 4'hB with last on the 2nd -> data=16'hAB00, len=8. With MSB_FIRST=0 -> data=16'h00BA, len=8.
- Back-pressure: hold ready_i=0 after word 16'h1234 completes -> data/len/val stay stable and data_ready_o=0. Stream bits meanwhile; none are consumed (ovf_cnt_o counts them if enabled). Raise ready_i for one cycle -> val drops; the next word assembles correctly.
- Back-to-back with ready_i=1, LANE_W=16: a beat every cycle -> val stays 1 continuously and data follows each beat with 1-cycle latency.
- Reset: drive srst_n_i=0 after 7 of 16 bits -> all outputs 0. The next full 16-bit word is assembled correctly with no leftover bits.

Source files
------------

// File: rtl/deserializer_lanes_if.sv
// Beat-in / word-out handshake bundle for deserializer_lanes.
// ovf_cnt_o exists only when DESERIALIZER_LANES_OVF_CNT_EN is defined.
interface deserializer_lanes_if #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 1
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic [LANE_W-1:0] data_i;
    logic              data_val_i;
    logic              data_last_i;
    logic              data_ready_o;
    logic [DATA_W-1:0] deser_data_o;
    logic [LEN_W-1:0]  deser_len_o;
    logic              deser_data_val_o;
    logic              deser_data_ready_i;

`ifdef DESERIALIZER_LANES_OVF_CNT_EN
    logic [15:0]       ovf_cnt_o;

    modport slave (
        input  data_i, data_val_i, data_last_i, deser_data_ready_i,
        output data_ready_o, deser_data_o, deser_len_o, deser_data_val_o, ovf_cnt_o
    );

    modport master (
        output data_i, data_val_i, data_last_i, deser_data_ready_i,
        input  data_ready_o, deser_data_o, deser_len_o, deser_data_val_o, ovf_cnt_o
    );
`else
    modport slave (
        input  data_i, data_val_i, data_last_i, deser_data_ready_i,
        output data_ready_o, deser_data_o, deser_len_o, deser_data_val_o
    );

    modport master (
        output data_i, data_val_i, data_last_i, deser_data_ready_i,
        input  data_ready_o, deser_data_o, deser_len_o, deser_data_val_o
    );
`endif
endinterface

// File: rtl/deserializer_lanes.sv
// Collects LANE_W-bit beats into DATA_W-bit words with last-flush and output back-pressure.
// Optional stall counter ovf_cnt_o: define DESERIALIZER_LANES_OVF_CNT_EN.
module deserializer_lanes #(
    parameter int DATA_W    = 16,
    parameter int LANE_W    = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                 clk_i,
    input logic                 srst_n_i,
    deserializer_lanes_if.slave bus
);
    localparam int BEATS = DATA_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_shift;
    logic [DATA_W-1:0] word_aligned;
    logic [LEN_W-1:0]  len_next;
    logic [LEN_W-1:0]  pad;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  len_q;
    logic              val_q;
    logic              ready;
    logic              accept;
    logic              complete;

    assign ready    = !val_q || bus.deser_data_ready_i;
    assign accept   = bus.data_val_i && ready;
    assign complete = accept && ((cnt == LAST_CNT) || bus.data_last_i);
    assign len_next = LEN_W'((int'(cnt) + 1) * LANE_W);
    assign pad      = LEN_W'(DATA_W) - len_next;

    // Partial words are justified toward the end the first beat landed in.
    always_comb begin
        asm_shift    = '0;
        word_aligned = '0;
        if (MSB_FIRST) begin
            asm_shift    = (asm_q << LANE_W) | DATA_W'(bus.data_i);
            word_aligned = asm_shift << pad;
        end else begin
            asm_shift    = (asm_q >> LANE_W) | (DATA_W'(bus.data_i) << (DATA_W - LANE_W));
            word_aligned = asm_shift >> pad;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            cnt    <= '0;
            asm_q  <= '0;
            data_q <= '0;
            len_q  <= '0;
            val_q  <= 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    cnt   <= '0;
                    asm_q <= '0;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                    asm_q <= asm_shift;
                end
            end
            // A fresh word wins over a handshake so consecutive words leave no bubble.
            if (complete) begin
                data_q <= word_aligned;
                len_q  <= len_next;
                val_q  <= 1'b1;
            end else if (val_q && bus.deser_data_ready_i) begin
                val_q  <= 1'b0;
            end
        end
    end

    assign bus.data_ready_o     = ready;
    assign bus.deser_data_o     = data_q;
    assign bus.deser_len_o      = len_q;
    assign bus.deser_data_val_o = val_q;

`ifdef DESERIALIZER_LANES_OVF_CNT_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            ovf_cnt <= '0;
        end else if (bus.data_val_i && !ready && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign bus.ovf_cnt_o = ovf_cnt;
`endif
endmodule

// File: tb/tb_deserializer_lanes.sv
// Directed bench for deserializer_lanes across four lane/bit-order configurations.
module tb_deserializer_lanes;
    logic clk;
    logic srst_n;
    int   checks;
    int   failures;

    deserializer_lanes_if #(.DATA_W(16), .LANE_W(1))  ifa ();
    deserializer_lanes_if #(.DATA_W(16), .LANE_W(4))  ifb ();
    deserializer_lanes_if #(.DATA_W(16), .LANE_W(4))  ifc ();
    deserializer_lanes_if #(.DATA_W(16), .LANE_W(16)) ifd ();

    deserializer_lanes #(.DATA_W(16), .LANE_W(1), .MSB_FIRST(1'b1)) dut_a (.clk_i(clk), .srst_n_i(srst_n), .bus(ifa));
    deserializer_lanes #(.DATA_W(16), .LANE_W(4), .MSB_FIRST(1'b0)) dut_b (.clk_i(clk), .srst_n_i(srst_n), .bus(ifb));
    deserializer_lanes #(.DATA_W(16), .LANE_W(4), .MSB_FIRST(1'b1)) dut_c (.clk_i(clk), .srst_n_i(srst_n), .bus(ifc));
    deserializer_lanes #(.DATA_W(16), .LANE_W(16), .MSB_FIRST(1'b1)) dut_d (.clk_i(clk), .srst_n_i(srst_n), .bus(ifd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word_a(input logic [15:0] w, output logic early);
        early = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            ifa.data_i     = w[i];
            ifa.data_val_i = 1'b1;
            cycle();
            if (i != 0 && ifa.deser_data_val_o) early = 1'b1;
        end
        ifa.data_val_i = 1'b0;
    endtask

    task automatic beat_bc(input logic [3:0] d, input logic v, input logic l);
        ifb.data_i = d; ifb.data_val_i = v; ifb.data_last_i = l;
        ifc.data_i = d; ifc.data_val_i = v; ifc.data_last_i = l;
        cycle();
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        cycle();
        cycle();
        checks++; if (ifa.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_val_a got=%b exp=0", ifa.deser_data_val_o); end
        checks++; if (ifa.deser_data_o !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data_a got=%h exp=0000", ifa.deser_data_o); end
        checks++; if (ifa.deser_len_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_len_a got=%0d exp=0", ifa.deser_len_o); end
        checks++; if (ifa.data_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_a got=%b exp=1", ifa.data_ready_o); end
        checks++; if (ifd.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_val_d got=%b exp=0", ifd.deser_data_val_o); end
        checks++; if (ifb.deser_len_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_len_b got=%0d exp=0", ifb.deser_len_o); end
`ifdef DESERIALIZER_LANES_OVF_CNT_EN
        checks++; if (ifa.ovf_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL reset_ovf got=%0d exp=0", ifa.ovf_cnt_o); end
`endif
        srst_n = 1'b1;
        cycle();
    endtask

    task automatic test_serial_words();
        logic [15:0] words [5];
        logic        early;
        words = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h1234, 16'h8001};
        for (int k = 0; k < 5; k++) begin
            send_word_a(words[k], early);
            checks++; if (early !== 1'b0) begin failures++; $display("[TB] FAIL serial_early word=%h got=%b exp=0", words[k], early); end
            checks++; if (ifa.deser_data_val_o !== 1'b1) begin failures++; $display("[TB] FAIL serial_val word=%h got=%b exp=1", words[k], ifa.deser_data_val_o); end
            checks++; if (ifa.deser_data_o !== words[k]) begin failures++; $display("[TB] FAIL serial_data got=%h exp=%h", ifa.deser_data_o, words[k]); end
            checks++; if (ifa.deser_len_o !== 5'd16) begin failures++; $display("[TB] FAIL serial_len got=%0d exp=16", ifa.deser_len_o); end
        end
        cycle();
        checks++; if (ifa.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL serial_val_drop got=%b exp=0", ifa.deser_data_val_o); end
    endtask

    task automatic test_lanes();
        beat_bc(4'h1, 1'b1, 1'b0);
        beat_bc(4'h2, 1'b1, 1'b0);
        beat_bc(4'h3, 1'b1, 1'b0);
        checks++; if (ifb.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL lane_latency got=%b exp=0", ifb.deser_data_val_o); end
        beat_bc(4'h4, 1'b1, 1'b0);
        checks++; if (ifb.deser_data_val_o !== 1'b1) begin failures++; $display("[TB] FAIL lane_val_b got=%b exp=1", ifb.deser_data_val_o); end
        checks++; if (ifb.deser_data_o !== 16'h4321) begin failures++; $display("[TB] FAIL lane_lsb_data got=%h exp=4321", ifb.deser_data_o); end
        checks++; if (ifb.deser_len_o !== 5'd16) begin failures++; $display("[TB] FAIL lane_lsb_len got=%0d exp=16", ifb.deser_len_o); end
        checks++; if (ifc.deser_data_o !== 16'h1234) begin failures++; $display("[TB] FAIL lane_msb_data got=%h exp=1234", ifc.deser_data_o); end
        beat_bc(4'h0, 1'b0, 1'b0);
        checks++; if (ifb.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL lane_val_drop got=%b exp=0", ifb.deser_data_val_o); end

        beat_bc(4'h5, 1'b1, 1'b0);
        beat_bc(4'hF, 1'b0, 1'b1);
        checks++; if (ifc.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL gap_last_ignored got=%b exp=0", ifc.deser_data_val_o); end
        beat_bc(4'h6, 1'b1, 1'b0);
        beat_bc(4'h7, 1'b1, 1'b0);
        beat_bc(4'h8, 1'b1, 1'b0);
        checks++; if (ifb.deser_data_o !== 16'h8765) begin failures++; $display("[TB] FAIL gap_lsb_data got=%h exp=8765", ifb.deser_data_o); end
        checks++; if (ifc.deser_data_o !== 16'h5678) begin failures++; $display("[TB] FAIL gap_msb_data got=%h exp=5678", ifc.deser_data_o); end

        beat_bc(4'hA, 1'b1, 1'b0);
        beat_bc(4'hB, 1'b1, 1'b1);
        checks++; if (ifc.deser_data_o !== 16'hAB00) begin failures++; $display("[TB] FAIL partial_msb_data got=%h exp=AB00", ifc.deser_data_o); end
        checks++; if (ifc.deser_len_o !== 5'd8) begin failures++; $display("[TB] FAIL partial_msb_len got=%0d exp=8", ifc.deser_len_o); end
        checks++; if (ifb.deser_data_o !== 16'h00BA) begin failures++; $display("[TB] FAIL partial_lsb_data got=%h exp=00BA", ifb.deser_data_o); end
        checks++; if (ifb.deser_len_o !== 5'd8) begin failures++; $display("[TB] FAIL partial_lsb_len got=%0d exp=8", ifb.deser_len_o); end

        beat_bc(4'h5, 1'b1, 1'b1);
        checks++; if (ifc.deser_data_o !== 16'h5000) begin failures++; $display("[TB] FAIL single_msb_data got=%h exp=5000", ifc.deser_data_o); end
        checks++; if (ifb.deser_data_o !== 16'h0005) begin failures++; $display("[TB] FAIL single_lsb_data got=%h exp=0005", ifb.deser_data_o); end
        checks++; if (ifb.deser_len_o !== 5'd4) begin failures++; $display("[TB] FAIL single_len got=%0d exp=4", ifb.deser_len_o); end

        beat_bc(4'hC, 1'b1, 1'b0);
        beat_bc(4'hD, 1'b1, 1'b0);
        beat_bc(4'hE, 1'b1, 1'b0);
        beat_bc(4'hF, 1'b1, 1'b1);
        checks++; if (ifc.deser_data_o !== 16'hCDEF) begin failures++; $display("[TB] FAIL last_full_data got=%h exp=CDEF", ifc.deser_data_o); end
        checks++; if (ifc.deser_len_o !== 5'd16) begin failures++; $display("[TB] FAIL last_full_len got=%0d exp=16", ifc.deser_len_o); end
        checks++; if (ifb.deser_data_o !== 16'hFEDC) begin failures++; $display("[TB] FAIL last_full_lsb got=%h exp=FEDC", ifb.deser_data_o); end
        beat_bc(4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic early;
        ifa.deser_data_ready_i = 1'b0;
        send_word_a(16'h1234, early);
        checks++; if (ifa.deser_data_o !== 16'h1234) begin failures++; $display("[TB] FAIL bp_data got=%h exp=1234", ifa.deser_data_o); end
        checks++; if (ifa.data_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready got=%b exp=0", ifa.data_ready_o); end
        ifa.data_i     = 1'b1;
        ifa.data_val_i = 1'b1;
        repeat (5) cycle();
        checks++; if (ifa.deser_data_o !== 16'h1234) begin failures++; $display("[TB] FAIL bp_hold_data got=%h exp=1234", ifa.deser_data_o); end
        checks++; if (ifa.deser_len_o !== 5'd16) begin failures++; $display("[TB] FAIL bp_hold_len got=%0d exp=16", ifa.deser_len_o); end
        checks++; if (ifa.deser_data_val_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_val got=%b exp=1", ifa.deser_data_val_o); end
        checks++; if (ifa.data_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_ready got=%b exp=0", ifa.data_ready_o); end
`ifdef DESERIALIZER_LANES_OVF_CNT_EN
        checks++; if (ifa.ovf_cnt_o !== 16'd5) begin failures++; $display("[TB] FAIL bp_ovf got=%0d exp=5", ifa.ovf_cnt_o); end
`endif
        ifa.data_val_i         = 1'b0;
        ifa.deser_data_ready_i = 1'b1;
        cycle();
        checks++; if (ifa.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_val got=%b exp=0", ifa.deser_data_val_o); end
        send_word_a(16'hBEEF, early);
        checks++; if (ifa.deser_data_o !== 16'hBEEF) begin failures++; $display("[TB] FAIL bp_next_data got=%h exp=BEEF", ifa.deser_data_o); end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [5];
        vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        for (int k = 0; k < 5; k++) begin
            ifd.data_i     = vals[k];
            ifd.data_val_i = 1'b1;
            cycle();
            checks++; if (ifd.deser_data_val_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_val k=%0d got=%b exp=1", k, ifd.deser_data_val_o); end
            checks++; if (ifd.deser_data_o !== vals[k]) begin failures++; $display("[TB] FAIL b2b_data got=%h exp=%h", ifd.deser_data_o, vals[k]); end
        end
        checks++; if (ifd.deser_len_o !== 5'd16) begin failures++; $display("[TB] FAIL b2b_len got=%0d exp=16", ifd.deser_len_o); end
        ifd.data_val_i = 1'b0;
        cycle();
        checks++; if (ifd.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_val_drop got=%b exp=0", ifd.deser_data_val_o); end
    endtask

    task automatic test_reset_mid_word();
        logic early;
        for (int i = 0; i < 7; i++) begin
            ifa.data_i     = 1'b1;
            ifa.data_val_i = 1'b1;
            cycle();
        end
        srst_n = 1'b0;
        cycle();
        checks++; if (ifa.deser_data_o !== 16'h0000) begin failures++; $display("[TB] FAIL midrst_data got=%h exp=0000", ifa.deser_data_o); end
        checks++; if (ifa.deser_len_o !== 5'd0) begin failures++; $display("[TB] FAIL midrst_len got=%0d exp=0", ifa.deser_len_o); end
        checks++; if (ifa.deser_data_val_o !== 1'b0) begin failures++; $display("[TB] FAIL midrst_val got=%b exp=0", ifa.deser_data_val_o); end
        srst_n         = 1'b1;
        ifa.data_val_i = 1'b0;
        cycle();
        send_word_a(16'h0F0F, early);
        checks++; if (ifa.deser_data_o !== 16'h0F0F) begin failures++; $display("[TB] FAIL midrst_next got=%h exp=0F0F", ifa.deser_data_o); end
        checks++; if (early !== 1'b0) begin failures++; $display("[TB] FAIL midrst_early got=%b exp=0", early); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        srst_n   = 1'b0;
        ifa.data_i = '0; ifa.data_val_i = 1'b0; ifa.data_last_i = 1'b0; ifa.deser_data_ready_i = 1'b1;
        ifb.data_i = '0; ifb.data_val_i = 1'b0; ifb.data_last_i = 1'b0; ifb.deser_data_ready_i = 1'b1;
        ifc.data_i = '0; ifc.data_val_i = 1'b0; ifc.data_last_i = 1'b0; ifc.deser_data_ready_i = 1'b1;
        ifd.data_i = '0; ifd.data_val_i = 1'b0; ifd.data_last_i = 1'b0; ifd.deser_data_ready_i = 1'b1;
        test_reset();
        test_serial_words();
        test_lanes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
